// File: rtl/nibble_serial_addsub_if.sv
// Handshake bundle for nibble_serial_addsub.
//   slave  : the adder side (accepts operands, presents the result)
//   master : the producer/consumer side driving operands and out_ready
// Signals: in_valid/in_ready + a, b, sub, cin (operation in);
//          out_valid/out_ready + sum, cout (result out).
interface nibble_serial_addsub_if #(
    parameter int unsigned WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport slave (
        input  in_valid, a, b, sub, cin, out_ready,
        output in_ready, out_valid, sum, cout
    );

    modport master (
        output in_valid, a, b, sub, cin, out_ready,
        input  in_ready, out_valid, sum, cout
    );
endinterface

// File: rtl/nibble_serial_addsub.sv
// Multi-cycle WIDTH-bit adder/subtractor built on a single 4-bit adder slice.
// One nibble is processed per clock, LSB nibble first, with the carry kept in
// a register between nibbles. One operation in flight.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous, active-high reset
//   bus  - nibble_serial_addsub_if.slave:
//          in_valid/in_ready, a, b, sub, cin    operation request
//          out_valid/out_ready, sum, cout       result (held until out_ready)
//   sub=0: sum = A + B + cin,  cout = carry out
//   sub=1: sum = A - B - cin,  cout = 1 for no borrow, 0 for borrow
module nibble_serial_addsub #(
    parameter int unsigned WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    nibble_serial_addsub_if.slave  bus
);
    localparam int unsigned NIB = WIDTH / 4;
    localparam int unsigned CW  = $clog2(NIB + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic             carry;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic [4:0]       slice;

    // The single add_4 slice: low nibbles of both shift registers plus carry.
    always_comb begin
        slice = {1'b0, a_sr[3:0]} + {1'b0, b_sr[3:0]} + {4'b0000, carry};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            a_sr   <= '0;
            b_sr   <= '0;
            carry  <= 1'b0;
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_sr   <= bus.a;
                        // Subtraction as A + ~B + 1; the borrow-in removes the +1.
                        b_sr   <= bus.sub ? ~bus.b : bus.b;
                        carry  <= bus.cin ^ bus.sub;
                        cnt    <= '0;
                        sum_q  <= '0;
                        cout_q <= 1'b0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    // Result nibbles enter from the MSB end so that after NIB
                    // shifts the first (LSB) nibble lands in sum[3:0].
                    sum_q <= {slice[3:0], sum_q[WIDTH-1:4]};
                    a_sr  <= a_sr >> 4;
                    b_sr  <= b_sr >> 4;
                    carry <= slice[4];
                    cnt   <= cnt + CW'(1);
                    if (cnt == CW'(NIB - 1)) begin
                        cout_q <= slice[4];
                        state  <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;

endmodule

// File: tb/tb_nibble_serial_addsub.sv
module tb_nibble_serial_addsub;
    localparam int unsigned WIDTH = 16;
    localparam int unsigned NIB   = WIDTH / 4;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    nibble_serial_addsub_if #(.WIDTH(WIDTH)) bus ();

    nibble_serial_addsub #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; sample/drive 1 time unit after the rising edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Present an operation, wait for accept, then wait for out_valid.
    // Returns result and the number of clocks from accept edge to out_valid.
    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic sub, input logic cin,
                          output logic [WIDTH-1:0] s, output logic c, output int lat);
        int n;
        bus.a = a; bus.b = b; bus.sub = sub; bus.cin = cin;
        bus.in_valid = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 50) begin
            tick();
            n++;
        end
        if (!bus.in_ready) check("accept_timeout", 32'd0, 32'd1);
        tick();
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 50) begin
            tick();
            lat++;
        end
        s = bus.sum;
        c = bus.cout;
    endtask

    task automatic handoff;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("ov_drop", 32'(bus.out_valid), 32'd0);
        check("ir_after", 32'(bus.in_ready), 32'd1);
    endtask

    typedef struct {
        string            tag;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             sub;
        logic             cin;
        logic [WIDTH-1:0] s;
        logic             c;
    } vec_t;

    vec_t vecs[6];

    initial begin
        logic [WIDTH-1:0] s;
        logic             c;
        int               lat;
        logic [WIDTH:0]   ref_full;

        vecs[0] = '{"add_1234_0fff", 16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0};
        vecs[1] = '{"add_ffff_0001", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1};
        vecs[2] = '{"add_0_0_cin",   16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0001, 1'b0};
        vecs[3] = '{"sub_1000_0001", 16'h1000, 16'h0001, 1'b1, 1'b0, 16'h0FFF, 1'b1};
        vecs[4] = '{"sub_0001_0002", 16'h0001, 16'h0002, 1'b1, 1'b0, 16'hFFFF, 1'b0};
        vecs[5] = '{"sub_5_3_bin",   16'h0005, 16'h0003, 1'b1, 1'b1, 16'h0001, 1'b1};

        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.a = '0; bus.b = '0; bus.sub = 1'b0; bus.cin = 1'b0;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        check("rst_in_ready",  32'(bus.in_ready),  32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_sum",       32'(bus.sum),       32'd0);
        check("rst_cout",      32'(bus.cout),      32'd0);

        // Directed vectors
        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].cin, s, c, lat);
            check({vecs[i].tag, "_sum"},  32'(s),   32'(vecs[i].s));
            check({vecs[i].tag, "_cout"}, 32'(c),   32'(vecs[i].c));
            check({vecs[i].tag, "_lat"},  32'(lat), NIB);
            handoff();
            check({vecs[i].tag, "_hold"}, 32'(bus.sum), 32'(vecs[i].s));
        end

        // Stall in DONE with a new request pending
        run_op(16'h1234, 16'h0FFF, 1'b0, 1'b0, s, c, lat);
        bus.a = 16'h00FF; bus.b = 16'h0001; bus.sub = 1'b0; bus.cin = 1'b0;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("stall_ov",   32'(bus.out_valid), 32'd1);
            check("stall_ir",   32'(bus.in_ready),  32'd0);
            check("stall_sum",  32'(bus.sum),       32'h2233);
            check("stall_cout", 32'(bus.cout),      32'd0);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("rel_ov",  32'(bus.out_valid), 32'd0);
        check("rel_ir",  32'(bus.in_ready),  32'd1);
        check("rel_sum", 32'(bus.sum),       32'h2233);
        run_op(16'h00FF, 16'h0001, 1'b0, 1'b0, s, c, lat);
        check("post_stall_sum",  32'(s), 32'h0100);
        check("post_stall_cout", 32'(c), 32'd0);
        handoff();

        // Reset after two nibbles processed
        bus.a = 16'hABCD; bus.b = 16'h1111; bus.sub = 1'b0; bus.cin = 1'b0;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_ir",   32'(bus.in_ready),  32'd1);
        check("midrst_ov",   32'(bus.out_valid), 32'd0);
        check("midrst_sum",  32'(bus.sum),       32'd0);
        check("midrst_cout", 32'(bus.cout),      32'd0);
        for (int i = 0; i < NIB + 2; i++) begin
            tick();
            check("midrst_no_ov", 32'(bus.out_valid), 32'd0);
        end
        run_op(16'h00FF, 16'h0001, 1'b0, 1'b0, s, c, lat);
        check("after_rst_sum",  32'(s), 32'h0100);
        check("after_rst_cout", 32'(c), 32'd0);
        handoff();

        // Random operations with throttled request and response
        for (int i = 0; i < 300; i++) begin
            logic [WIDTH-1:0] ra, rb;
            logic             rs, rc;
            int               gap;
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            rs = 1'($urandom);
            rc = 1'($urandom);
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) tick();
            ref_full = {1'b0, ra} + {1'b0, (rs ? ~rb : rb)} + (WIDTH+1)'(rc ^ rs);
            run_op(ra, rb, rs, rc, s, c, lat);
            check("rnd_sum",  32'(s),   32'(ref_full[WIDTH-1:0]));
            check("rnd_cout", 32'(c),   32'(ref_full[WIDTH]));
            check("rnd_lat",  32'(lat), NIB);
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) tick();
            check("rnd_ov_held", 32'(bus.out_valid), 32'd1);
            handoff();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
